dsm_stereo_ctrl: RTL

DSM_STEREO_CTRL -- requirements
Module: dsm_stereo_ctrl

---
 rtl/dsm_ctrl_pkg.sv | 16 +
 rtl/dsm_ctrl_fifo.sv | 54 +++++
 rtl/dsm_stereo_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dsm_ctrl_pkg.sv
// dsm_ctrl_pkg: shared types and helpers for the stereo delta-sigma front-end
// controller (dsm_stereo_ctrl and its FIFO).
package dsm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } dsm_state_t;

  // Silence code for an offset-binary word of the given width: 2^(width-1).
  function automatic logic [31:0] dsm_mid(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsm_ctrl_fifo.sv
// dsm_ctrl_fifo: small synchronous FIFO holding packed stereo sample pairs.
// Pointers carry one extra wrap bit so level/full/empty fall out of a subtract.
// A flush empties the FIFO and takes priority over a same-cycle push.
module dsm_ctrl_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    aclr,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointer update with asynchronous clear and synchronous flush.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dsm_stereo_ctrl.sv
// dsm_stereo_ctrl: buffers upstream stereo PCM pairs, paces them out on a
// programmable sample tick and drives the registered modulator input words.
// Optional feature macro: DSM_CTRL_SOFTMUTE_EN -- when defined, outputs ramp
// toward their target by RAMP_STEP per tick instead of jumping.
module dsm_stereo_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int unsigned DSM_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 12,
  parameter int unsigned RAMP_STEP  = 64
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DSM_WIDTH-1:0]          s_left,
  input  logic [DSM_WIDTH-1:0]          s_right,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic                          enable,
  input  logic                          mute,
  output logic [DSM_WIDTH-1:0]          left_pcm,
  output logic [DSM_WIDTH-1:0]          right_pcm,
  output logic                          sample_tick,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DSM_WIDTH-1:0] MID = DSM_WIDTH'(dsm_mid(DSM_WIDTH));
  localparam logic [LW-1:0] PREFILL_LVL = LW'(FIFO_DEPTH / 2);

  dsm_state_t               state;
  dsm_state_t               state_nxt;
  logic [DIV_WIDTH-1:0]     cnt;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     flush;
  logic                     go_idle;
  logic                     underrun_set;
  logic [2*DSM_WIDTH-1:0]   fifo_rd;
  logic [DSM_WIDTH-1:0]     pop_l;
  logic [DSM_WIDTH-1:0]     pop_r;

  // Tick is forced low while the asynchronous clear is held.
  assign sample_tick  = enable && !aclr && (cnt == div);
  assign s_ready      = !fifo_full;
  assign push         = s_valid && !fifo_full;
  assign go_idle      = !enable || (state == ST_IDLE);
  assign flush        = go_idle;
  assign pop          = (state == ST_PLAY) && sample_tick && !fifo_empty;
  assign underrun_set = (state == ST_PLAY) && sample_tick && fifo_empty;
  assign {pop_l, pop_r} = fifo_rd;

  dsm_ctrl_fifo #(
    .DATA_WIDTH (2 * DSM_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aclr    (aclr),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({s_left, s_right}),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sample-period divider: counts 0..div while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)                cnt <= '0;
    else if (!enable)        cnt <= '0;
    else if (cnt == div)     cnt <= '0;
    else                     cnt <= cnt + DIV_WIDTH'(1);
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_PREFILL;
        ST_PREFILL: if (fifo_level >= PREFILL_LVL) state_nxt = ST_PLAY;
        ST_PLAY:    if (underrun_set) state_nxt = ST_PREFILL;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Sticky underrun flag; a new underrun beats a same-cycle clear.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)              underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

`ifdef DSM_CTRL_SOFTMUTE_EN
  localparam logic [DSM_WIDTH-1:0] STEP = DSM_WIDTH'(RAMP_STEP);

  logic [DSM_WIDTH-1:0] ramp_l;
  logic [DSM_WIDTH-1:0] ramp_r;
  logic [DSM_WIDTH-1:0] tgt_l;
  logic [DSM_WIDTH-1:0] tgt_r;

  function automatic logic [DSM_WIDTH-1:0] step_toward(
    input logic [DSM_WIDTH-1:0] cur,
    input logic [DSM_WIDTH-1:0] tgt
  );
    if (cur < tgt) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else           return ((cur - tgt) > STEP) ? cur - STEP : tgt;
  endfunction

  // Ramp target: silence while muted, else the freshest popped sample.
  always_comb begin
    tgt_l = ramp_l;
    tgt_r = ramp_r;
    if (pop) begin
      tgt_l = pop_l;
      tgt_r = pop_r;
    end
    if (mute) begin
      tgt_l = MID;
      tgt_r = MID;
    end
  end

  // Ramp registers remember the last popped pair; outputs slew on each tick.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ramp_l    <= MID;
      ramp_r    <= MID;
      left_pcm  <= MID;
      right_pcm <= MID;
    end else if (go_idle) begin
      ramp_l    <= MID;
      ramp_r    <= MID;
      left_pcm  <= MID;
      right_pcm <= MID;
    end else begin
      if (pop) begin
        ramp_l <= pop_l;
        ramp_r <= pop_r;
      end
      if (sample_tick) begin
        left_pcm  <= step_toward(left_pcm, tgt_l);
        right_pcm <= step_toward(right_pcm, tgt_r);
      end
    end
  end
`else
  // Output words: silence in IDLE or while muted, else the popped pair.
  // After mute release the silence code is held until the next pop.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      left_pcm  <= MID;
      right_pcm <= MID;
    end else if (go_idle || mute) begin
      left_pcm  <= MID;
      right_pcm <= MID;
    end else if (pop) begin
      left_pcm  <= pop_l;
      right_pcm <= pop_r;
    end
  end
`endif

endmodule
